// File: rtl/tile_map_scanner.sv
// Background-redraw sequencer: walks the visible tile window of the map ROM
// and hands each tile to the 8x8 drawer over its Enable/Done handshake.
module tile_map_scanner #(
  parameter int MAP_COLS_LOG2 = 6,
  parameter int SCREEN_COLS   = 20,
  parameter int SCREEN_ROWS   = 15
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic                     Start,
  input  logic [MAP_COLS_LOG2-1:0] ScrollCol,
  output logic [MAP_COLS_LOG2+3:0] MapAddress,
  input  logic [3:0]               MapData,
  output logic [7:0]               TileX,
  output logic [6:0]               TileY,
  output logic [3:0]               TileSel,
  output logic                     TileEnable,
  input  logic                     TileDone,
  output logic                     Busy,
  output logic                     FrameDone
);

  localparam int MW = MAP_COLS_LOG2;
  localparam logic [4:0] LAST_COL = 5'(SCREEN_COLS - 1);
  localparam logic [3:0] LAST_ROW = 4'(SCREEN_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LATCH,
    S_ENABLE,
    S_RELEASE,
    S_NEXT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      scol_q, scol_d;
  logic [3:0]      srow_q, srow_d;
  logic [MW-1:0]   base_q, base_d;
  logic [3:0]      tile_sel_q, tile_sel_d;
  logic            tile_enable_q, tile_enable_d;
  logic [MW-1:0]   mapcol;

  // Column wraps at the map edge because the carry out of this add is dropped.
  assign mapcol     = base_q + MW'(scol_q);
  assign MapAddress = {srow_q, mapcol};
  assign TileX      = {scol_q, 3'b000};
  assign TileY      = {srow_q, 3'b000};
  assign TileSel    = tile_sel_q;
  assign TileEnable = tile_enable_q;
  assign Busy       = (state_q != S_IDLE);
  assign FrameDone  = (state_q == S_DONE);

  always_comb begin
    state_d    = state_q;
    scol_d     = scol_q;
    srow_d     = srow_q;
    base_d     = base_q;
    tile_sel_d = tile_sel_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          base_d  = ScrollCol;
          scol_d  = '0;
          srow_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  state_d = S_LATCH;
      S_LATCH: begin
        tile_sel_d = MapData;
        state_d    = S_ENABLE;
      end
      S_ENABLE: begin
        if (TileDone) state_d = S_RELEASE;
      end
      // The drawer must drop Done before the next tile may be offered.
      S_RELEASE: begin
        if (!TileDone) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (scol_q < LAST_COL) begin
          scol_d  = scol_q + 5'd1;
          state_d = S_FETCH;
        end else if (srow_q < LAST_ROW) begin
          scol_d  = '0;
          srow_d  = srow_q + 4'd1;
          state_d = S_FETCH;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    tile_enable_d = (state_d == S_ENABLE);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q       <= S_IDLE;
      scol_q        <= '0;
      srow_q        <= '0;
      base_q        <= '0;
      tile_sel_q    <= '0;
      tile_enable_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      scol_q        <= scol_d;
      srow_q        <= srow_d;
      base_q        <= base_d;
      tile_sel_q    <= tile_sel_d;
      tile_enable_q <= tile_enable_d;
    end
  end

endmodule

// File: tb/tb_tile_map_scanner.sv
// Scoreboard bench for tile_map_scanner: a frame-level model queues expected
// tiles, a monitor pops them on each TileEnable rise; ROM and drawer are modelled.
module tb_tile_map_scanner;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b1;
  logic       Start = 1'b0;
  logic [5:0] ScrollCol = '0;
  logic [9:0] MapAddress;
  logic [3:0] MapData;
  logic [7:0] TileX;
  logic [6:0] TileY;
  logic [3:0] TileSel;
  logic       TileEnable;
  logic       TileDone = 1'b0;
  logic       Busy;
  logic       FrameDone;

  tile_map_scanner dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .ScrollCol(ScrollCol),
    .MapAddress(MapAddress), .MapData(MapData), .TileX(TileX), .TileY(TileY),
    .TileSel(TileSel), .TileEnable(TileEnable), .TileDone(TileDone),
    .Busy(Busy), .FrameDone(FrameDone)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [9:0] addr;
    logic [3:0] sel;
    logic [7:0] x;
    logic [6:0] y;
  } tile_t;

  tile_t      exp_q[$];
  logic [3:0] rom[1024];
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Registered map ROM: data appears one cycle after the address.
  always @(posedge Clock) MapData <= rom[MapAddress];

  // Drawer: raises Done cur_d cycles after seeing Enable, drops it cur_r
  // cycles after Enable falls.
  int cur_d = 1, cur_r = 1, dcnt = 0;
  bit rand_mode = 0;
  always @(negedge Clock) begin
    if (!Resetn) begin
      TileDone = 1'b0;
      dcnt = 0;
    end else if (TileEnable && !TileDone) begin
      dcnt++;
      if (dcnt >= cur_d) begin TileDone = 1'b1; dcnt = 0; end
    end else if (!TileEnable && TileDone) begin
      dcnt++;
      if (dcnt >= cur_r) begin
        TileDone = 1'b0;
        dcnt = 0;
        if (rand_mode) begin
          cur_d = $urandom_range(1, 3);
          cur_r = $urandom_range(1, 6);
        end
      end
    end
  end

  // Reference: one frame is every visible tile in row-major order, with the
  // map column wrapping modulo the map width.
  int frames_pending = 0;
  task automatic push_frame(input int base);
    tile_t t;
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 20; c++) begin
        t.addr = 10'(r * 64 + (base + c) % 64);
        t.sel  = rom[t.addr];
        t.x    = 8'(c * 8);
        t.y    = 7'(r * 8);
        exp_q.push_back(t);
      end
    frames_pending++;
  endtask

  // Monitor, sampling 1 time unit after each rising edge.
  int    cyc = 0, last_fall_cyc = 0, tiles_in_frame = 0, tiles_seen = 0, fd_count = 0;
  bit    prev_en = 0, prev_done = 0, prev_fd = 0, first_tile = 1;
  tile_t snap;
  always @(posedge Clock) begin
    #1;
    cyc++;
    if (!Resetn) begin
      prev_en = 0; prev_done = 0; prev_fd = 0;
      tiles_in_frame = 0; first_tile = 1;
    end else begin
      if (TileEnable && !prev_en) begin
        if (exp_q.size() == 0) begin
          check("tile_expected", 32'(exp_q.size()), 1);
        end else begin
          snap = exp_q.pop_front();
          check("map_address", 32'(MapAddress), 32'(snap.addr));
          check("tile_sel", 32'(TileSel), 32'(snap.sel));
          check("tile_x", 32'(TileX), 32'(snap.x));
          check("tile_y", 32'(TileY), 32'(snap.y));
        end
        if (!first_tile) check("done_low_to_next_enable", 32'(cyc - last_fall_cyc), 4);
        first_tile = 0;
        tiles_in_frame++;
        tiles_seen++;
      end
      if (!TileEnable && prev_en) begin
        check("enable_drops_on_done", 32'(TileDone && !prev_done), 1);
        check("hold_through_enable", 32'({TileX, TileY, TileSel, MapAddress}),
              32'({snap.x, snap.y, snap.sel, snap.addr}));
      end
      if (!TileDone && prev_done) begin
        last_fall_cyc = cyc;
        check("hold_through_release", 32'({TileX, TileY, TileSel, MapAddress}),
              32'({snap.x, snap.y, snap.sel, snap.addr}));
        check("enable_low_in_release", 32'(TileEnable), 0);
      end
      if (prev_fd) check("framedone_one_cycle", 32'(FrameDone), 0);
      if (FrameDone) begin
        fd_count++;
        check("framedone_expected", 32'(frames_pending > 0), 1);
        if (frames_pending > 0) frames_pending--;
        check("tiles_per_frame", 32'(tiles_in_frame), 300);
        tiles_in_frame = 0;
        first_tile = 1;
      end
      prev_en = TileEnable; prev_done = TileDone; prev_fd = FrameDone;
    end
  end

  task automatic start_frame(input logic [5:0] sc, input bit hold);
    @(negedge Clock);
    Start = 1'b1;
    ScrollCol = sc;
    push_frame(int'(sc));
    @(negedge Clock);
    check("busy_after_start", 32'(Busy), 1);
    if (!hold) Start = 1'b0;
    ScrollCol = 6'($urandom);
  endtask

  task automatic wait_frame(input bit perturb);
    int n = 0;
    forever begin
      @(negedge Clock);
      n++;
      if (FrameDone) begin
        if (perturb) Start = 1'b0;
        break;
      end
      if (n > 60000) begin
        check("frame_timeout", 32'(n), 0);
        break;
      end
      if (perturb) begin
        Start = ($urandom_range(0, 15) == 0);
        ScrollCol = 6'($urandom);
      end
    end
  endtask

  initial begin
    int t0, n, fd_before;
    for (int a = 0; a < 1024; a++) rom[a] = 4'(a % 16);

    #1 Resetn = 1'b0;
    #1;
    check("rst_enable", 32'(TileEnable), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_framedone", 32'(FrameDone), 0);
    check("rst_addr", 32'(MapAddress), 0);
    check("rst_xy", 32'({TileX, TileY}), 0);
    check("rst_sel", 32'(TileSel), 0);
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    check("idle_busy", 32'(Busy), 0);

    // Slow drawer, no scroll, address-pattern ROM
    cur_d = 130; cur_r = 1;
    start_frame(6'd0, 1'b0);
    wait_frame(1'b0);
    @(negedge Clock);
    check("busy_falls_after_done", 32'(Busy), 0);

    // Wrap across the map edge; drawer lingers in release
    cur_d = 2; cur_r = 5;
    start_frame(6'd50, 1'b0);
    wait_frame(1'b0);
    @(negedge Clock);
    check("busy_falls_after_done", 32'(Busy), 0);

    // Random ROM, scroll, drawer timing, mid-scan Start/ScrollCol noise
    rand_mode = 1;
    for (int f = 0; f < 2; f++) begin
      for (int a = 0; a < 1024; a++) rom[a] = 4'($urandom);
      start_frame(6'($urandom), 1'b0);
      wait_frame(1'b1);
      @(negedge Clock);
      check("busy_falls_after_done", 32'(Busy), 0);
    end

    // Start held high: re-trigger right after FrameDone
    rand_mode = 0; cur_d = 1; cur_r = 1;
    start_frame(6'd33, 1'b1);
    ScrollCol = 6'd61;
    wait_frame(1'b0);
    push_frame(61);
    @(negedge Clock);
    check("retrigger_idle_gap", 32'(Busy), 0);
    @(negedge Clock);
    check("retrigger_busy", 32'(Busy), 1);
    Start = 1'b0;
    wait_frame(1'b0);
    @(negedge Clock);
    check("busy_falls_after_done", 32'(Busy), 0);

    // Reset while the fifth tile is being drawn
    cur_d = 3; cur_r = 1;
    t0 = tiles_seen;
    start_frame(6'd7, 1'b0);
    n = 0;
    while (!((tiles_seen - t0 >= 5) && TileEnable) && n < 500) begin
      @(negedge Clock);
      n++;
    end
    check("reached_tile5", 32'(n < 500), 1);
    #2 Resetn = 1'b0;
    #1;
    check("midrst_enable", 32'(TileEnable), 0);
    check("midrst_busy", 32'(Busy), 0);
    check("midrst_framedone", 32'(FrameDone), 0);
    check("midrst_sel", 32'(TileSel), 0);
    check("midrst_addr", 32'(MapAddress), 0);
    exp_q.delete();
    frames_pending = 0;
    fd_before = fd_count;
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    repeat (60) @(negedge Clock);
    check("no_framedone_after_reset", 32'(fd_count), 32'(fd_before));
    check("idle_after_reset", 32'(Busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tile_map_scanner.md
# tile_map_scanner

Upstream sequencer for the 8x8 tile drawer. On a start request it walks the visible 20x15 tile window of a 64x15 background tile map, fetches each tile index from synchronous map ROM, and hands one tile at a time to the tile drawer using the drawer's Enable/Done four-phase handshake. A horizontal scroll column selects which 20 map columns are visible, with wrap-around at the map edge. It is the background-redraw engine for the side-scroller frame.

## Interface
Parameters:
- MAP_COLS_LOG2, 6, log2 of map width in tiles (64 columns).
- SCREEN_COLS, 20, visible tile columns (160 px / 8).
- SCREEN_ROWS, 15, visible tile rows (120 px / 8).

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  reset; asynchronous, active-low.
- Start  in  1  level; a frame scan begins on any IDLE cycle where Start=1.
- ScrollCol  in  6  leftmost visible map column; sampled only in the cycle Start is accepted.
- MapAddress  out  10  map ROM address = {row[3:0], mapcol[5:0]}.
- MapData  in  4  tile index from map ROM, valid 1 cycle after MapAddress (registered ROM).
- TileX  out  8  pixel X of current tile = screen column * 8 (drives drawer Xin).
- TileY  out  7  pixel Y of current tile = screen row * 8 (drives drawer Yin).
- TileSel  out  4  tile index for the drawer; registered.
- TileEnable  out  1  drawer Enable; registered.
- TileDone  in  1  drawer Done.
- Busy  out  1  high from accept of Start until FrameDone.
- FrameDone  out  1  one-cycle pulse after the last tile's handshake completes.

## Operation
- Registers: scol (0..19, 5 b), srow (0..14, 4 b), base (6 b, latched ScrollCol), TileSel, TileEnable, state.
- mapcol = (base + scol) mod 64 (6-bit add, carry discarded). MapAddress is combinational from srow/mapcol.
- States and transitions:
  - IDLE: Busy=0. Start=1 -> latch base, clear scol/srow, go FETCH.
  - FETCH: MapAddress presented; -> WAIT.
  - WAIT: ROM latency cycle; -> LATCH.
  - LATCH: TileSel <= MapData; -> ENABLE.
  - ENABLE: TileEnable=1; hold until TileDone=1, then -> RELEASE.
  - RELEASE: TileEnable=0; hold until TileDone=0, then -> NEXT.
  - NEXT: if scol<19: scol++ -> FETCH. Else if srow<14: scol<=0, srow++ -> FETCH. Else -> DONE.
  - DONE: FrameDone=1 for this cycle; -> IDLE.
- TileX/TileY/TileSel held stable for the entire ENABLE and RELEASE states (the drawer reads them combinationally throughout its draw).
- Start during a scan is ignored; Start held high re-triggers a new scan on the IDLE cycle after DONE.
- ScrollCol changes mid-scan have no effect (base is latched).
- Scan order: row-major, left to right, top to bottom; 300 tiles per frame.

## Timing
- Reset (async assert): state=IDLE, scol=srow=base=0, TileSel=0, TileEnable=0, Busy=0, FrameDone=0; MapAddress=0, TileX=0, TileY=0. Deassertion is used synchronously; first transition possible on the first rising edge after Resetn rises.
- Reset mid-scan: TileEnable drops immediately; scan abandoned, no FrameDone.
- Per tile overhead excluding drawer time: FETCH+WAIT+LATCH+NEXT = 4 cycles, plus ENABLE cycles (until Done) and RELEASE cycles (until Done falls).
- TileEnable rises at the edge entering ENABLE; never reasserted before TileDone has been observed low.
- TileDone=1 seen in RELEASE (drawer not yet released) -> remain in RELEASE; no timeout.
- Busy rises the edge after Start accepted, falls the edge leaving DONE.

## Test plan
- Reset mid-ENABLE of tile 5 -> TileEnable=0, Busy=0 immediately, state IDLE; no FrameDone afterwards without a new Start.
- ScrollCol=0, map ROM = (address mod 16), drawer model with 130-cycle Done delay -> 300 handshakes; tile (scol=3,srow=2) gets MapAddress=131, TileSel=3, TileX=24, TileY=16; one FrameDone pulse after tile (19,14) at TileX=152, TileY=112.
- ScrollCol=50 -> screen column 13 reads mapcol 63, column 14 reads mapcol 0 (row 1: MapAddress 127 then 64).
- Drawer holds Done high 5 cycles after Enable drops -> scanner stays in RELEASE 5 cycles; next TileEnable only after Done=0 plus 4 overhead cycles.
- Start pulsed in ENABLE, ScrollCol changed mid-scan -> no restart, mapping uses original base; Start held high continuously -> second scan begins the cycle after FrameDone.
